// File: rtl/ins_fetcher.sv
// ins_fetcher: single-outstanding instruction fetch FSM feeding the insq.
// Optional feature macro: STATIC_JAL_EN (follow JAL targets at fetch time).
module ins_fetcher (
   input  logic        clk,
   input  logic        reset,
   input  logic        ready,
   input  logic        clear,
   input  logic [31:0] clear_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   input  logic        insq_full,
   output logic        push,
   output logic [31:0] push_ins,
   output logic [31:0] push_pc
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DISCARD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        push_q, push_d;
   logic [31:0] push_ins_q, push_ins_d;
   logic [31:0] push_pc_q, push_pc_d;

   logic [31:0] seq_pc;
   logic [31:0] next_pc;
   logic        can_issue;

   assign seq_pc = pc_q + 32'd4;

`ifdef STATIC_JAL_EN
   logic        is_jal;
   logic [31:0] jal_imm;

   assign is_jal  = (mem_data[6:0] == 7'b1101111);
   assign jal_imm = {{11{mem_data[31]}},
                     mem_data[31],
                     mem_data[19:12],
                     mem_data[20],
                     mem_data[30:21],
                     1'b0};
   assign next_pc = is_jal ? (pc_q + jal_imm) : seq_pc;
`else
   assign next_pc = seq_pc;
`endif

   // A push in flight is not yet visible in insq_full.
   assign can_issue = !insq_full && !push_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      push_d     = push_q;
      push_ins_d = push_ins_q;
      push_pc_d  = push_pc_q;

      if (clear) begin
         pc_d   = clear_pc;
         push_d = 1'b0;
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            WAIT: begin
               if (mem_done) begin
                  mem_req_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  state_d = DISCARD;
               end
            end
            DISCARD: begin
               if (mem_done) begin
                  mem_req_d = 1'b0;
                  state_d   = IDLE;
               end
            end
            default: begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         endcase
      end else if (ready) begin
         push_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (can_issue) begin
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_q;
                  state_d    = WAIT;
               end
            end
            WAIT: begin
               if (mem_done) begin
                  mem_req_d  = 1'b0;
                  push_d     = 1'b1;
                  push_ins_d = mem_data;
                  push_pc_d  = pc_q;
                  pc_d       = next_pc;
                  state_d    = IDLE;
               end
            end
            DISCARD: begin
               if (mem_done) begin
                  mem_req_d = 1'b0;
                  state_d   = IDLE;
               end
            end
            default: begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= 32'd0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'd0;
         push_q     <= 1'b0;
         push_ins_q <= 32'd0;
         push_pc_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         push_q     <= push_d;
         push_ins_q <= push_ins_d;
         push_pc_q  <= push_pc_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign push     = push_q;
   assign push_ins = push_ins_q;
   assign push_pc  = push_pc_q;

endmodule
